victory_checker_param: RTL and testbench
========================================

Name: victory_checker_param

Overview:
- Parametrised successor to the fixed 6x7, 4-in-a-row victory checker.
- Scans the board around the cell just played and reports whether that move completes a run of WIN_LEN same-colour pieces on any of four axes.
- Method: bidirectional run-length counting with early termination, reading the board through a single synchronous-read port.
- Sits between the game-control FSM, which pulses start after a piece drops, and the board memory.

Parameters:
- ROWS, 6: board rows (2..16).
- COLS, 7: board columns (2..16).
- WIN_LEN, 4: run length that wins (2..min(ROWS,COLS)).
- ROW_W, 3: row index width; at least clog2(ROWS).
- COL_W, 3: column index width; at least clog2(COLS).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; accepted only in IDLE
- move_row  in  ROW_W  row of the placed piece; sampled on start acceptance
- move_col  in  COL_W  column of the placed piece; sampled on start acceptance
- data_in  in  2  board cell contents (00 empty, 01 P1, 10 P2, 11 reserved); valid the cycle after rd_row/rd_col
- rd_row  out  ROW_W  registered board read row
- rd_col  out  COL_W  registered board read column
- busy  out  1  high from the cycle after acceptance until DONE inclusive
- done  out  1  one-cycle pulse at end of check
- winner  out  2  00 no win, else winning player code
- win_axis  out  2  0 vertical, 1 horizontal, 2 diagonal (+r,+c), 3 anti-diagonal (+r,-c); valid when winner != 00
- bad_move  out  1  with done: move coordinates were out of range

Behaviour:
- Reset: clock and reset are one clock and a synchronous active-high reset, as decided. rst=1 on any edge forces IDLE and clears every output to 0. No done pulse follows a reset taken mid-operation.
- States: IDLE, ORG_RD, ORG_CK, STEP, ADDR, PROBE, DONE.
- IDLE:
  - On start, latch the move and load rd_* with the move coordinates.
  - Clear winner, win_axis and bad_move; go to ORG_RD.
  - start in any other state is ignored, including the DONE cycle.
- ORG_RD: memory read of the origin cell in flight. Next state ORG_CK.
- ORG_CK:
  - If move_row>=ROWS or move_col>=COLS: bad_move=1, go to DONE.
  - Else if data_in is 00 or 11: go to DONE with winner=00.
  - Else latch player=data_in, set axis=0, dir=+, k=1, count=1; go to STEP.
- STEP:
  - Target = origin + k*sign*delta(axis), using signed arithmetic one bit wider than the index.
  - Target off-board (<0 or >=ROWS/COLS) or k>WIN_LEN-1: switch direction and stay in STEP.
    - If dir was +: set dir=- and k=1.
    - If dir was -: next axis, dir=+, k=1, count=1.
    - If axis was already 3: go to DONE with winner=00.
  - Target valid: load rd_* with the target, go to ADDR.
- ADDR: memory read in flight. Next state PROBE.
- PROBE:
  - data_in==player: count++, k++. If count>=WIN_LEN, set winner=player and win_axis=axis, then go to DONE (early exit). Otherwise go to STEP.
  - Mismatch: apply the direction switch described under STEP, then go to STEP.
- DONE: done=1 for one cycle, then IDLE. winner, win_axis and bad_move hold until the next accepted start or reset.
- Axis order: 0,1,2,3. Within each axis, + direction before -. Coordinates never wrap at board edges.
- count width: clog2(WIN_LEN+1). Per-axis count never exceeds 2*WIN_LEN-1 before early exit.
- Each valid probe costs 3 cycles. Each off-board or limit switch costs 1 cycle in STEP.

Test Plan:
- Empty origin: board all 00, start with (2,3) at cycle 0 -> done at cycle 3, winner=00, no reads beyond (2,3).
- Horizontal win: P1 at (0,1),(0,2),(0,3),(0,4), everything else empty, start with (0,3) at cycle 0 -> done at cycle 19, winner=01, win_axis=1.
- Vertical win with the origin on top: P2 at (0..3,5), start with (3,5) -> winner=10, win_axis=0; three-high stack -> winner=00.
- Edge, no wrap: P1 at (0,0),(1,6),(2,5),(3,4), start with (0,0) -> winner=00; no rd_col value >=7 ever issued.
- Generalisation: ROWS=8, COLS=8, WIN_LEN=5, P1 diagonal (2,2)..(6,6), start with (4,4) -> winner=01, win_axis=2; the same with only 4 pieces -> 00.
- Robustness:
  - Out-of-range move (6,0) at defaults -> done at cycle 3 with bad_move=1, winner=00.
  - start pulsed while busy -> ignored.
  - rst asserted in PROBE -> all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/victory_checker_param.sv
`default_nettype none
// ============================================================================
//  Module      : victory_checker_param
//  Description : Parametrised connect-N victory checker. Walks outward from
//                the cell just played along four axes, counting same-colour
//                pieces through one synchronous-read board port.
//  Revision    : 1.0 - initial release
// ============================================================================
module victory_checker_param #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4,
    parameter int ROW_W   = 3,
    parameter int COL_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ROW_W-1:0] move_row,
    input  logic [COL_W-1:0] move_col,
    input  logic [1:0]       data_in,
    output logic [ROW_W-1:0] rd_row,
    output logic [COL_W-1:0] rd_col,
    output logic             busy,
    output logic             done,
    output logic [1:0]       winner,
    output logic [1:0]       win_axis,
    output logic             bad_move
);

    localparam int c_CNT_W = $clog2(WIN_LEN + 1);
    localparam int c_RC_W  = (ROW_W > COL_W) ? ROW_W : COL_W;
    // Signed target width leaves headroom so origin +/- k can never alias on-board.
    localparam int c_TGT_W = ((c_RC_W > c_CNT_W) ? c_RC_W : c_CNT_W) + 2;

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_ORG_RD = 3'd1;
    localparam logic [2:0] c_S_ORG_CK = 3'd2;
    localparam logic [2:0] c_S_STEP   = 3'd3;
    localparam logic [2:0] c_S_ADDR   = 3'd4;
    localparam logic [2:0] c_S_PROBE  = 3'd5;
    localparam logic [2:0] c_S_DONE   = 3'd6;

    logic [2:0]         r_state,    w_state_nxt;
    logic [ROW_W-1:0]   r_move_row, w_move_row_nxt;
    logic [COL_W-1:0]   r_move_col, w_move_col_nxt;
    logic [1:0]         r_player,   w_player_nxt;
    logic [1:0]         r_axis,     w_axis_nxt;
    logic               r_dir_neg,  w_dir_neg_nxt;
    logic [c_CNT_W-1:0] r_k,        w_k_nxt;
    logic [c_CNT_W-1:0] r_count,    w_count_nxt;
    logic [ROW_W-1:0]   r_rd_row,   w_rd_row_nxt;
    logic [COL_W-1:0]   r_rd_col,   w_rd_col_nxt;
    logic               r_busy,     w_busy_nxt;
    logic               r_done,     w_done_nxt;
    logic [1:0]         r_winner,   w_winner_nxt;
    logic [1:0]         r_win_axis, w_win_axis_nxt;
    logic               r_bad_move, w_bad_move_nxt;

    logic signed [c_TGT_W-1:0] w_k_s, w_org_r, w_org_c;
    logic signed [c_TGT_W-1:0] w_off_r, w_off_c, w_tgt_r, w_tgt_c;
    logic                      w_tgt_ok;
    logic                      w_sw_last;
    logic [1:0]                w_sw_axis;
    logic [c_CNT_W-1:0]        w_sw_count;
    logic [c_CNT_W-1:0]        w_cnt_inc;
    logic                      w_move_oob;

    assign w_k_s   = $signed(c_TGT_W'(r_k));
    assign w_org_r = $signed(c_TGT_W'(r_move_row));
    assign w_org_c = $signed(c_TGT_W'(r_move_col));

    // Axis deltas: 0 (+1,0), 1 (0,+1), 2 (+1,+1), 3 (+1,-1); dir_neg negates both.
    assign w_off_r = (r_axis == 2'd1) ? '0 : (r_dir_neg ? -w_k_s : w_k_s);
    assign w_off_c = (r_axis == 2'd0) ? '0 :
                     (r_axis == 2'd3) ? (r_dir_neg ? w_k_s : -w_k_s) :
                                        (r_dir_neg ? -w_k_s : w_k_s);
    assign w_tgt_r = w_org_r + w_off_r;
    assign w_tgt_c = w_org_c + w_off_c;

    assign w_tgt_ok = !w_tgt_r[c_TGT_W-1] && (w_tgt_r < $signed(c_TGT_W'(ROWS)))
                   && !w_tgt_c[c_TGT_W-1] && (w_tgt_c < $signed(c_TGT_W'(COLS)))
                   && (32'(r_k) <= WIN_LEN - 1);

    assign w_sw_last  = r_dir_neg && (r_axis == 2'd3);
    assign w_sw_axis  = r_dir_neg ? r_axis + 2'd1 : r_axis;
    assign w_sw_count = r_dir_neg ? c_CNT_W'(1) : r_count;
    assign w_cnt_inc  = r_count + c_CNT_W'(1);
    assign w_move_oob = (32'(r_move_row) >= ROWS) || (32'(r_move_col) >= COLS);

    always_comb begin
        w_state_nxt    = r_state;
        w_move_row_nxt = r_move_row;
        w_move_col_nxt = r_move_col;
        w_player_nxt   = r_player;
        w_axis_nxt     = r_axis;
        w_dir_neg_nxt  = r_dir_neg;
        w_k_nxt        = r_k;
        w_count_nxt    = r_count;
        w_rd_row_nxt   = r_rd_row;
        w_rd_col_nxt   = r_rd_col;
        w_winner_nxt   = r_winner;
        w_win_axis_nxt = r_win_axis;
        w_bad_move_nxt = r_bad_move;

        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_move_row_nxt = move_row;
                    w_move_col_nxt = move_col;
                    w_rd_row_nxt   = move_row;
                    w_rd_col_nxt   = move_col;
                    w_winner_nxt   = 2'b00;
                    w_win_axis_nxt = 2'b00;
                    w_bad_move_nxt = 1'b0;
                    w_state_nxt    = c_S_ORG_RD;
                end
            end
            c_S_ORG_RD: w_state_nxt = c_S_ORG_CK;
            c_S_ORG_CK: begin
                if (w_move_oob) begin
                    w_bad_move_nxt = 1'b1;
                    w_state_nxt    = c_S_DONE;
                end else if (data_in == 2'b00 || data_in == 2'b11) begin
                    w_state_nxt = c_S_DONE;
                end else begin
                    w_player_nxt  = data_in;
                    w_axis_nxt    = 2'd0;
                    w_dir_neg_nxt = 1'b0;
                    w_k_nxt       = c_CNT_W'(1);
                    w_count_nxt   = c_CNT_W'(1);
                    w_state_nxt   = c_S_STEP;
                end
            end
            c_S_STEP: begin
                if (w_tgt_ok) begin
                    w_rd_row_nxt = w_tgt_r[ROW_W-1:0];
                    w_rd_col_nxt = w_tgt_c[COL_W-1:0];
                    w_state_nxt  = c_S_ADDR;
                end else begin
                    w_dir_neg_nxt = ~r_dir_neg;
                    w_axis_nxt    = w_sw_axis;
                    w_k_nxt       = c_CNT_W'(1);
                    w_count_nxt   = w_sw_count;
                    w_state_nxt   = w_sw_last ? c_S_DONE : c_S_STEP;
                end
            end
            c_S_ADDR: w_state_nxt = c_S_PROBE;
            c_S_PROBE: begin
                if (data_in == r_player) begin
                    w_count_nxt = w_cnt_inc;
                    w_k_nxt     = r_k + c_CNT_W'(1);
                    if (32'(w_cnt_inc) >= WIN_LEN) begin
                        w_winner_nxt   = r_player;
                        w_win_axis_nxt = r_axis;
                        w_state_nxt    = c_S_DONE;
                    end else begin
                        w_state_nxt = c_S_STEP;
                    end
                end else begin
                    w_dir_neg_nxt = ~r_dir_neg;
                    w_axis_nxt    = w_sw_axis;
                    w_k_nxt       = c_CNT_W'(1);
                    w_count_nxt   = w_sw_count;
                    w_state_nxt   = w_sw_last ? c_S_DONE : c_S_STEP;
                end
            end
            c_S_DONE: w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != c_S_IDLE);
        w_done_nxt = (w_state_nxt == c_S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_move_row <= '0;
            r_move_col <= '0;
            r_player   <= '0;
            r_axis     <= '0;
            r_dir_neg  <= 1'b0;
            r_k        <= '0;
            r_count    <= '0;
            r_rd_row   <= '0;
            r_rd_col   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_winner   <= '0;
            r_win_axis <= '0;
            r_bad_move <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_move_row <= w_move_row_nxt;
            r_move_col <= w_move_col_nxt;
            r_player   <= w_player_nxt;
            r_axis     <= w_axis_nxt;
            r_dir_neg  <= w_dir_neg_nxt;
            r_k        <= w_k_nxt;
            r_count    <= w_count_nxt;
            r_rd_row   <= w_rd_row_nxt;
            r_rd_col   <= w_rd_col_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_winner   <= w_winner_nxt;
            r_win_axis <= w_win_axis_nxt;
            r_bad_move <= w_bad_move_nxt;
        end
    end

    assign rd_row   = r_rd_row;
    assign rd_col   = r_rd_col;
    assign busy     = r_busy;
    assign done     = r_done;
    assign winner   = r_winner;
    assign win_axis = r_win_axis;
    assign bad_move = r_bad_move;

endmodule
`default_nettype wire

// File: tb/tb_victory_checker_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_victory_checker_param
//  Description : Directed bench for victory_checker_param, default 6x7/4 board
//                plus an 8x8/5 instance, each fed by a synchronous-read board.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_victory_checker_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b;
    logic [2:0] mr_a, mc_a, mr_b, mc_b;
    logic [1:0] din_a, din_b;
    logic [2:0] rd_row_a, rd_col_a, rd_row_b, rd_col_b;
    logic       busy_a, done_a, bad_a, busy_b, done_b, bad_b;
    logic [1:0] win_a, axis_a, win_b, axis_b;

    logic [1:0] board_a [0:15][0:15];
    logic [1:0] board_b [0:15][0:15];

    int checks = 0;
    int errors = 0;

    victory_checker_param #(.ROWS(6), .COLS(7), .WIN_LEN(4), .ROW_W(3), .COL_W(3)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .move_row(mr_a), .move_col(mc_a),
        .data_in(din_a), .rd_row(rd_row_a), .rd_col(rd_col_a), .busy(busy_a),
        .done(done_a), .winner(win_a), .win_axis(axis_a), .bad_move(bad_a));

    victory_checker_param #(.ROWS(8), .COLS(8), .WIN_LEN(5), .ROW_W(3), .COL_W(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .move_row(mr_b), .move_col(mc_b),
        .data_in(din_b), .rd_row(rd_row_b), .rd_col(rd_col_b), .busy(busy_b),
        .done(done_b), .winner(win_b), .win_axis(axis_b), .bad_move(bad_b));

    always @(posedge clk) begin
        din_a <= board_a[rd_row_a][rd_col_a];
        din_b <= board_b[rd_row_b][rd_col_b];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_boards();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                board_a[r][c] = 2'b00;
                board_b[r][c] = 2'b00;
            end
    endtask

    task automatic sample(input int sel, output logic d, output logic b, output logic [1:0] w,
                          output logic [1:0] ax, output logic bm, output logic [2:0] rr,
                          output logic [2:0] rc);
        if (sel == 0) begin
            d = done_a; b = busy_a; w = win_a; ax = axis_a; bm = bad_a; rr = rd_row_a; rc = rd_col_a;
        end else begin
            d = done_b; b = busy_b; w = win_b; ax = axis_b; bm = bad_b; rr = rd_row_b; rc = rd_col_b;
        end
    endtask

    // Called at a negedge; start is accepted on the following posedge (cycle 0).
    task automatic run(input string tag, input int sel, input int r, input int c,
                       input int rows, input int cols, input int pulse_at, input int exp_cyc,
                       input logic [1:0] exp_win, input logic [1:0] exp_axis, input logic exp_bad,
                       output bit range_bad, output bit other_rd);
        int cyc;
        bit seen;
        logic d, b, bm;
        logic [1:0] w, ax;
        logic [2:0] rr, rc;
        cyc = 0; seen = 0; range_bad = 0; other_rd = 0;
        if (sel == 0) begin mr_a = 3'(r); mc_a = 3'(c); start_a = 1'b1; end
        else          begin mr_b = 3'(r); mc_b = 3'(c); start_b = 1'b1; end
        @(posedge clk);
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0; start_b = 1'b0;
            if (cyc == pulse_at) begin
                if (sel == 0) begin mr_a = 3'd5; mc_a = 3'd5; start_a = 1'b1; end
                else          begin mr_b = 3'd5; mc_b = 3'd5; start_b = 1'b1; end
            end
            sample(sel, d, b, w, ax, bm, rr, rc);
            if (32'(rr) >= rows || 32'(rc) >= cols) range_bad = 1;
            if (32'(rr) != r || 32'(rc) != c) other_rd = 1;
            if (d) seen = 1;
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            if (exp_cyc >= 0) check({tag, "_done_cycle"}, cyc, exp_cyc);
            check({tag, "_winner"}, w, exp_win);
            if (exp_win != 2'b00) check({tag, "_axis"}, ax, exp_axis);
            check({tag, "_bad_move"}, bm, exp_bad);
            check({tag, "_busy_at_done"}, b, 1);
        end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        sample(sel, d, b, w, ax, bm, rr, rc);
        check({tag, "_idle_after"}, {d, b}, 2'b00);
        check({tag, "_hold"}, {w, bm}, {exp_win, exp_bad});
    endtask

    initial begin
        bit rb, oth, any_done;
        logic d, b, bm;
        logic [1:0] w, ax;
        logic [2:0] rr, rc;

        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        mr_a = '0; mc_a = '0; mr_b = '0; mc_b = '0;
        clear_boards();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sample(0, d, b, w, ax, bm, rr, rc);
        check("reset_a", {d, b, w, ax, bm, rr, rc}, '0);
        sample(1, d, b, w, ax, bm, rr, rc);
        check("reset_b", {d, b, w, ax, bm, rr, rc}, '0);

        // Empty board: only the origin is ever read.
        run("empty", 0, 2, 3, 6, 7, -1, 3, 2'b00, 2'b00, 1'b0, rb, oth);
        check("empty_no_probe", 32'(oth), 0);

        // Horizontal P1 row 0 cols 1..4; a stray start mid-run must be ignored.
        for (int c = 1; c <= 4; c++) board_a[0][c] = 2'b01;
        run("horiz", 0, 0, 3, 6, 7, 5, 19, 2'b01, 2'd1, 1'b0, rb, oth);

        // Vertical P2 col 5 rows 0..3; start pulsed during DONE must be ignored.
        clear_boards();
        for (int r = 0; r <= 3; r++) board_a[r][5] = 2'b10;
        run("vert", 0, 3, 5, 6, 7, 15, 15, 2'b10, 2'd0, 1'b0, rb, oth);
        board_a[0][5] = 2'b00;
        run("vert3", 0, 3, 5, 6, 7, -1, -1, 2'b00, 2'd0, 1'b0, rb, oth);

        // A wrapping implementation would join (0,0) with the (1,6)..(3,4) diagonal.
        clear_boards();
        board_a[0][0] = 2'b01; board_a[1][6] = 2'b01;
        board_a[2][5] = 2'b01; board_a[3][4] = 2'b01;
        run("edge", 0, 0, 0, 6, 7, -1, -1, 2'b00, 2'd0, 1'b0, rb, oth);
        check("edge_rd_in_range", 32'(rb), 0);

        run("oob", 0, 6, 0, 6, 7, -1, 3, 2'b00, 2'd0, 1'b1, rb, oth);

        // Reset while the first probe (cycle 5) is in PROBE.
        clear_boards();
        for (int c = 1; c <= 4; c++) board_a[0][c] = 2'b01;
        mr_a = 3'd0; mc_a = 3'd3; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        check("probe_busy", busy_a, 1);
        rst = 1'b1;
        @(negedge clk);
        sample(0, d, b, w, ax, bm, rr, rc);
        check("rst_probe_outputs", {d, b, w, ax, bm, rr, rc}, '0);
        rst = 1'b0;
        any_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_a || busy_a) any_done = 1;
        end
        check("rst_probe_no_done", 32'(any_done), 0);

        // 8x8, WIN_LEN=5 diagonal.
        clear_boards();
        for (int i = 2; i <= 6; i++) board_b[i][i] = 2'b01;
        run("diag5", 1, 4, 4, 8, 8, -1, -1, 2'b01, 2'd2, 1'b0, rb, oth);
        board_b[6][6] = 2'b00;
        run("diag4", 1, 4, 4, 8, 8, -1, -1, 2'b00, 2'd0, 1'b0, rb, oth);
        check("diag4_rd_in_range", 32'(rb), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
